// File: rtl/pll_seq_pkg.sv
// -----------------------------------------------------------------------------
// pll_seq_pkg
// Shared definitions for the PLL reset sequencer:
//   - seq_state_t : FSM state encodings (PLL_RST..FAULT), 3 bits wide so that
//                   the unused codes 5-7 are representable and can be recovered.
//   - cnt_width() : width of the shared cycle counter, sized for the largest of
//                   the three programmable intervals.
//   - UNLOCK_W    : width of the saturating lock-loss counter.
// -----------------------------------------------------------------------------
package pll_seq_pkg;

    typedef enum logic [2:0] {
        ST_PLL_RST   = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_STABLE    = 3'd2,
        ST_RUN       = 3'd3,
        ST_FAULT     = 3'd4
    } seq_state_t;

    localparam int UNLOCK_W = 8;

    // The counter only ever needs to reach (interval - 1), so $clog2 of the
    // largest interval is enough. A 1-bit floor keeps the vector legal when
    // every interval is 1.
    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/pll_reset_sequencer_sync.sv
// -----------------------------------------------------------------------------
// sync_2ff
// Generic 1-bit multi-flop synchronizer (default two stages) for bringing an
// asynchronous level into the clk domain. Output latency is STAGES cycles.
// Ports:
//   clk   in  1  destination clock
//   srst  in  1  synchronous active-high reset, clears every stage to 0
//   d     in  1  asynchronous input level
//   q     out 1  synchronized level
// -----------------------------------------------------------------------------
module sync_2ff #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic srst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] stage_reg;
    logic [STAGES-1:0] stage_next;

    // Stage 0 captures the raw input, every later stage captures its
    // predecessor.
    genvar gi;
    generate
        for (gi = 0; gi < STAGES; gi++) begin : g_stage
            if (gi == 0) begin : g_first
                assign stage_next[gi] = d;
            end else begin : g_rest
                assign stage_next[gi] = stage_reg[gi-1];
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (srst) begin
            stage_reg <= '0;
        end else begin
            stage_reg <= stage_next;
        end
    end

    assign q = stage_reg[STAGES-1];

endmodule

// File: rtl/pll_reset_sequencer.sv
// -----------------------------------------------------------------------------
// pll_reset_sequencer
// Supervises a PLL: pulses its reset, waits for lock, requires lock to stay
// up for STABLE_CYCLES before releasing the downstream system reset, retries
// after a lock timeout and latches a fault once retries are exhausted. A lock
// loss while running restarts the whole sequence and is counted.
// Runs on the free-running reference clock, never on the PLL output.
// Ports:
//   clock_in        in   1   reference clock
//   rst_in          in   1   synchronous active-high reset (dominant)
//   pll_lock_in     in   1   PLL lock, asynchronous
//   pll_rst_out     out  1   reset to the PLL, active-high
//   sys_rst_out     out  1   downstream system reset, active-high
//   ready_out       out  1   high while in RUN
//   fault_out       out  1   sticky fault, cleared only by rst_in
//   retry_cnt_out   out  RW  timed-out attempts since last RUN
//   unlock_cnt_out  out  8   lock losses seen in RUN, saturating
//   state_out       out  3   current FSM state encoding
// All outputs are registered and reflect the state entered on the same edge.
// -----------------------------------------------------------------------------
module pll_reset_sequencer
    import pll_seq_pkg::*;
#(
    parameter int RST_CYCLES    = 16,
    parameter int LOCK_TIMEOUT  = 10000,
    parameter int STABLE_CYCLES = 1000,
    parameter int MAX_RETRIES   = 3
) (
    input  logic                                 clock_in,
    input  logic                                 rst_in,
    input  logic                                 pll_lock_in,
    output logic                                 pll_rst_out,
    output logic                                 sys_rst_out,
    output logic                                 ready_out,
    output logic                                 fault_out,
    output logic [$clog2(MAX_RETRIES+2)-1:0]     retry_cnt_out,
    output logic [UNLOCK_W-1:0]                  unlock_cnt_out,
    output logic [2:0]                           state_out
);

    localparam int CW = cnt_width(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES);
    localparam int RW = $clog2(MAX_RETRIES + 2);

    // Terminal counts: the counter starts at 0 on state entry, so the Nth
    // cycle in a state is the one where the counter reads N-1.
    localparam logic [CW-1:0] RST_LAST     = CW'(RST_CYCLES - 1);
    localparam logic [CW-1:0] TIMEOUT_LAST = CW'(LOCK_TIMEOUT - 1);
    localparam logic [CW-1:0] STABLE_LAST  = CW'(STABLE_CYCLES - 1);
    localparam logic [RW-1:0] RETRY_MAX    = RW'(MAX_RETRIES);
    localparam logic [UNLOCK_W-1:0] UNLOCK_SAT = '1;

    logic lock_s;

    seq_state_t          state_reg,   state_next;
    logic [CW-1:0]       cnt_reg,     cnt_next;
    logic [RW-1:0]       retry_reg,   retry_next;
    logic [UNLOCK_W-1:0] unlock_reg,  unlock_next;
    logic                pll_rst_reg, pll_rst_next;
    logic                sys_rst_reg, sys_rst_next;
    logic                ready_reg,   ready_next;
    logic                fault_reg,   fault_next;

    sync_2ff #(
        .STAGES (2)
    ) u_lock_sync (
        .clk  (clock_in),
        .srst (rst_in),
        .d    (pll_lock_in),
        .q    (lock_s)
    );

    always_ff @(posedge clock_in) begin
        if (rst_in) begin
            state_reg   <= ST_PLL_RST;
            cnt_reg     <= '0;
            retry_reg   <= '0;
            unlock_reg  <= '0;
            pll_rst_reg <= 1'b1;
            sys_rst_reg <= 1'b1;
            ready_reg   <= 1'b0;
            fault_reg   <= 1'b0;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            retry_reg   <= retry_next;
            unlock_reg  <= unlock_next;
            pll_rst_reg <= pll_rst_next;
            sys_rst_reg <= sys_rst_next;
            ready_reg   <= ready_next;
            fault_reg   <= fault_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg + 1'b1;
        retry_next  = retry_reg;
        unlock_next = unlock_reg;

        case (state_reg)
            ST_PLL_RST: begin
                if (cnt_reg == RST_LAST) begin
                    state_next = ST_WAIT_LOCK;
                end
            end
            ST_WAIT_LOCK: begin
                // Lock is tested first so a lock arriving on the timeout
                // cycle still wins and costs no retry.
                if (lock_s) begin
                    state_next = ST_STABLE;
                end else if (cnt_reg == TIMEOUT_LAST) begin
                    if (retry_reg == RETRY_MAX) begin
                        state_next = ST_FAULT;
                    end else begin
                        retry_next = retry_reg + 1'b1;
                        state_next = ST_PLL_RST;
                    end
                end
            end
            ST_STABLE: begin
                // A drop on the final qualifying cycle beats the release.
                if (!lock_s) begin
                    state_next = ST_WAIT_LOCK;
                end else if (cnt_reg == STABLE_LAST) begin
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                cnt_next = '0;
                if (!lock_s) begin
                    state_next = ST_PLL_RST;
                    if (unlock_reg != UNLOCK_SAT) begin
                        unlock_next = unlock_reg + 1'b1;
                    end
                end
            end
            ST_FAULT: begin
                cnt_next = '0;
            end
            default: begin
                // Unused encodings recover through a full PLL reset.
                state_next = ST_PLL_RST;
            end
        endcase

        if (state_next != state_reg) begin
            cnt_next = '0;
        end

        if (state_next == ST_RUN) begin
            retry_next = '0;
        end

        // Outputs are decoded from the state being entered so they change on
        // the same edge as the state register.
        pll_rst_next = (state_next == ST_PLL_RST) || (state_next == ST_FAULT);
        sys_rst_next = (state_next != ST_RUN);
        ready_next   = (state_next == ST_RUN);
        fault_next   = fault_reg || (state_next == ST_FAULT);
    end

    assign pll_rst_out    = pll_rst_reg;
    assign sys_rst_out    = sys_rst_reg;
    assign ready_out      = ready_reg;
    assign fault_out      = fault_reg;
    assign retry_cnt_out  = retry_reg;
    assign unlock_cnt_out = unlock_reg;
    assign state_out      = state_reg;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// -----------------------------------------------------------------------------
// tb_pll_reset_sequencer
// Directed bench for pll_reset_sequencer with RST_CYCLES=4, LOCK_TIMEOUT=20,
// STABLE_CYCLES=8, MAX_RETRIES=2. Edge numbers in the comments count rising
// edges after the reset edge (edge 0). A lock value driven before edge k
// reaches the FSM decision at edge k+2.
// -----------------------------------------------------------------------------
module tb_pll_reset_sequencer;

    localparam int RST_CYCLES    = 4;
    localparam int LOCK_TIMEOUT  = 20;
    localparam int STABLE_CYCLES = 8;
    localparam int MAX_RETRIES   = 2;
    localparam int NVEC          = 41;

    logic       clock_in = 1'b0;
    logic       rst_in;
    logic       pll_lock_in;
    logic       pll_rst_out;
    logic       sys_rst_out;
    logic       ready_out;
    logic       fault_out;
    logic [1:0] retry_cnt_out;
    logic [7:0] unlock_cnt_out;
    logic [2:0] state_out;

    always #5 clock_in = ~clock_in;

    pll_reset_sequencer #(
        .RST_CYCLES    (RST_CYCLES),
        .LOCK_TIMEOUT  (LOCK_TIMEOUT),
        .STABLE_CYCLES (STABLE_CYCLES),
        .MAX_RETRIES   (MAX_RETRIES)
    ) dut (
        .clock_in       (clock_in),
        .rst_in         (rst_in),
        .pll_lock_in    (pll_lock_in),
        .pll_rst_out    (pll_rst_out),
        .sys_rst_out    (sys_rst_out),
        .ready_out      (ready_out),
        .fault_out      (fault_out),
        .retry_cnt_out  (retry_cnt_out),
        .unlock_cnt_out (unlock_cnt_out),
        .state_out      (state_out)
    );

    typedef struct packed {
        logic [2:0] st;
        logic       pll_rst;
        logic       sys_rst;
        logic       ready;
        logic       fault;
        logic [1:0] retry;
        logic [7:0] unlock;
    } obs_t;

    typedef struct {
        logic rst;
        logic lock;
        obs_t exp;
    } vec_t;

    vec_t vecs [NVEC];

    int check_count = 0;
    int pass_count  = 0;
    int cyc         = 0;

    // Expected output image of each state.
    function automatic obs_t ex(input logic [2:0] st, input logic [1:0] retry,
                                input logic [7:0] unlock);
        obs_t o;
        o.st      = st;
        o.pll_rst = (st == 3'd0) || (st == 3'd4);
        o.sys_rst = (st != 3'd3);
        o.ready   = (st == 3'd3);
        o.fault   = (st == 3'd4);
        o.retry   = retry;
        o.unlock  = unlock;
        return o;
    endfunction

    function automatic obs_t sample();
        obs_t o;
        o.st      = state_out;
        o.pll_rst = pll_rst_out;
        o.sys_rst = sys_rst_out;
        o.ready   = ready_out;
        o.fault   = fault_out;
        o.retry   = retry_cnt_out;
        o.unlock  = unlock_cnt_out;
        return o;
    endfunction

    task automatic check(input string name, input obs_t exp_in, input bit ignore_retry);
        obs_t act;
        obs_t e;
        act = sample();
        e   = exp_in;
        if (ignore_retry) begin
            act.retry = '0;
            e.retry   = '0;
        end
        check_count++;
        if (act === e) begin
            pass_count++;
            $display("ok   %-10s cyc=%0d st=%0d pll=%0b sys=%0b rdy=%0b flt=%0b retry=%0d unlock=%0d",
                     name, cyc, act.st, act.pll_rst, act.sys_rst, act.ready, act.fault,
                     act.retry, act.unlock);
        end else begin
            $display("FAIL %s cyc=%0d got st=%0d pll=%0b sys=%0b rdy=%0b flt=%0b retry=%0d unlock=%0d want st=%0d pll=%0b sys=%0b rdy=%0b flt=%0b retry=%0d unlock=%0d",
                     name, cyc, act.st, act.pll_rst, act.sys_rst, act.ready, act.fault,
                     act.retry, act.unlock, e.st, e.pll_rst, e.sys_rst, e.ready, e.fault,
                     e.retry, e.unlock);
        end
    endtask

    task automatic tick();
        @(posedge clock_in);
        #1;
        cyc++;
    endtask

    task automatic advance_to(input int n);
        while (cyc < n) tick();
    endtask

    task automatic do_reset();
        rst_in = 1'b1;
        tick();
        rst_in = 1'b0;
        cyc = 0;
    endtask

    task automatic wait_run(input string name, input int budget);
        int k;
        k = 0;
        while (state_out !== 3'd3 && k < budget) begin
            tick();
            k++;
        end
        check_count++;
        if (state_out === 3'd3) begin
            pass_count++;
        end else begin
            $display("FAIL %s cyc=%0d got st=%0d want st=3 within %0d cycles",
                     name, cyc, state_out, budget);
        end
    endtask

    // One-cycle lock drop while in RUN: the sequencer must be back in
    // PLL_RST (both resets high) three edges after the drop is driven.
    task automatic unlock_pulse(input int n);
        pll_lock_in = 1'b0;
        tick();
        pll_lock_in = 1'b1;
        tick();
        tick();
        check($sformatf("drop%0d", n), ex(3'd0, 2'd0, (n > 255) ? 8'd255 : 8'(n)), 1'b0);
        wait_run($sformatf("relock%0d", n), 60);
    endtask

    initial begin
        rst_in      = 1'b1;
        pll_lock_in = 1'b0;

        // Vector table: lock up from cycle 10 (release at edge 20), then one
        // dropped lock cycle at 23 (back to PLL_RST at 25, RUN again at 38).
        for (int i = 0; i < NVEC; i++) begin
            logic [2:0] st;
            st = (i < 4)  ? 3'd0 :
                 (i < 12) ? 3'd1 :
                 (i < 20) ? 3'd2 :
                 (i < 25) ? 3'd3 :
                 (i < 29) ? 3'd0 :
                 (i < 30) ? 3'd1 :
                 (i < 38) ? 3'd2 : 3'd3;
            vecs[i].rst  = (i == 0);
            vecs[i].lock = (i >= 10) && (i != 23);
            vecs[i].exp  = ex(st, 2'd0, (i >= 25) ? 8'd1 : 8'd0);
        end

        for (int i = 0; i < NVEC; i++) begin
            rst_in      = vecs[i].rst;
            pll_lock_in = vecs[i].lock;
            tick();
            check($sformatf("vec%0d", i), vecs[i].exp, 1'b0);
        end
        rst_in = 1'b0;

        // Repeated lock losses: the counter saturates at 255.
        for (int n = 2; n <= 300; n++) begin
            unlock_pulse(n);
            if (n == 2 || n == 254 || n == 255 || n == 300)
                check($sformatf("sat%0d", n), ex(3'd3, 2'd0, (n > 255) ? 8'd255 : 8'(n)), 1'b0);
        end

        // Reset during RUN clears everything and restarts the sequence.
        do_reset();
        check("t6_run_rst", ex(3'd0, 2'd0, 8'd0), 1'b0);
        advance_to(3);  check("t6_prst", ex(3'd0, 2'd0, 8'd0), 1'b0);
        advance_to(4);  check("t6_wait", ex(3'd1, 2'd0, 8'd0), 1'b0);
        advance_to(13); check("t6_run", ex(3'd3, 2'd0, 8'd0), 1'b0);

        // Lock drop on the last STABLE cycle (count 7): drop wins.
        do_reset();
        advance_to(10);
        pll_lock_in = 1'b0;
        tick();
        pll_lock_in = 1'b1;
        check("t3_stab", ex(3'd2, 2'd0, 8'd0), 1'b0);
        advance_to(12); check("t3_cnt7", ex(3'd2, 2'd0, 8'd0), 1'b0);
        advance_to(13); check("t3_drop", ex(3'd1, 2'd0, 8'd0), 1'b0);
        advance_to(14); check("t3_restab", ex(3'd2, 2'd0, 8'd0), 1'b0);
        advance_to(21); check("t3_hold", ex(3'd2, 2'd0, 8'd0), 1'b0);
        advance_to(22); check("t3_run", ex(3'd3, 2'd0, 8'd0), 1'b0);

        // Lock reaching the FSM exactly on the second timeout cycle (edge 48).
        pll_lock_in = 1'b0;
        do_reset();
        advance_to(24); check("t5_to1", ex(3'd0, 2'd1, 8'd0), 1'b0);
        advance_to(45);
        pll_lock_in = 1'b1;
        advance_to(47); check("t5_pre", ex(3'd1, 2'd1, 8'd0), 1'b0);
        advance_to(48); check("t5_lockwin", ex(3'd2, 2'd1, 8'd0), 1'b0);
        advance_to(55); check("t5_stab", ex(3'd2, 2'd1, 8'd0), 1'b0);
        advance_to(56); check("t5_run", ex(3'd3, 2'd0, 8'd0), 1'b0);

        // Same, but lock one cycle late: the timeout fires first.
        pll_lock_in = 1'b0;
        do_reset();
        advance_to(46);
        pll_lock_in = 1'b1;
        advance_to(48); check("t5b_to2", ex(3'd0, 2'd2, 8'd0), 1'b0);
        advance_to(61); check("t5b_run", ex(3'd3, 2'd0, 8'd0), 1'b0);

        // Lock never rises: two retries then FAULT at edge 72.
        pll_lock_in = 1'b0;
        do_reset();
        advance_to(23); check("t2_w1", ex(3'd1, 2'd0, 8'd0), 1'b0);
        advance_to(24); check("t2_to1", ex(3'd0, 2'd1, 8'd0), 1'b0);
        advance_to(47); check("t2_w2", ex(3'd1, 2'd1, 8'd0), 1'b0);
        advance_to(48); check("t2_to2", ex(3'd0, 2'd2, 8'd0), 1'b0);
        advance_to(71); check("t2_w3", ex(3'd1, 2'd2, 8'd0), 1'b0);
        advance_to(72); check("t2_fault", ex(3'd4, 2'd0, 8'd0), 1'b1);
        pll_lock_in = 1'b1;
        for (int i = 0; i < 100; i++) begin
            tick();
            check("t2_hold", ex(3'd4, 2'd0, 8'd0), 1'b1);
        end

        // Reset during FAULT clears the fault and restarts.
        do_reset();
        check("t6_flt_rst", ex(3'd0, 2'd0, 8'd0), 1'b0);
        advance_to(4);  check("t6f_wait", ex(3'd1, 2'd0, 8'd0), 1'b0);
        advance_to(5);  check("t6f_stab", ex(3'd2, 2'd0, 8'd0), 1'b0);
        advance_to(13); check("t6f_run", ex(3'd3, 2'd0, 8'd0), 1'b0);

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog cyc=%0d got no end of test want finish before time limit", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
